// File: rtl/baud_cfg_ctrl.sv
// Baud divisor programming sequencer sharing the SPART bus-write port with a TX byte source.
// Optional macro DIV_SKIP_SAME_EN: skip bus writes when a request repeats the programmed divisor.
module baud_cfg_ctrl #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [1:0] ADDR_TX       = 2'b00,
    parameter logic [1:0] ADDR_DBL      = 2'b10,
    parameter logic [1:0] ADDR_DBH      = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        update,
    output logic        AK,
    input  logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        tx_grant,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    output logic [7:0]  databus_out,
    output logic [15:0] cur_divisor,
    output logic        cfg_busy,
    output logic        cfg_err
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        WR_LO,
        WR_HI,
        SETTLE,
        TX_WR
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [15:0]   div_q_reg;
    logic [CW-1:0] cnt_reg;
    logic [15:0]   cur_divisor_reg;
    logic          skip_same;

    logic          ak_reg;
    logic          tx_grant_reg;
    logic          iocs_reg;
    logic          iorw_reg;
    logic [1:0]    ioaddr_reg;
    logic [7:0]    databus_reg;
    logic          cfg_busy_reg;
    logic          cfg_err_reg;

    logic          wr_next;
    logic [1:0]    ioaddr_next;
    logic [7:0]    databus_next;

`ifdef DIV_SKIP_SAME_EN
    // A fresh reset leaves the SPART divisor unknown, so the first request always writes.
    logic prog_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_done_reg <= 1'b0;
        end else if (state_reg == WR_HI) begin
            prog_done_reg <= 1'b1;
        end
    end

    assign skip_same = prog_done_reg && (div_q_reg == cur_divisor_reg);
`else
    assign skip_same = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (update) begin
                    state_next = ACK;
                end else if (tx_req && tbr) begin
                    state_next = TX_WR;
                end
            end
            ACK: begin
                if (div_q_reg == 16'd0 || skip_same) begin
                    state_next = IDLE;
                end else begin
                    state_next = WR_LO;
                end
            end
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = SETTLE;
            SETTLE: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            TX_WR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divisor is captured as the request is accepted; it is held stable through ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q_reg       <= 16'd0;
            cnt_reg         <= '0;
            cur_divisor_reg <= 16'd0;
        end else begin
            if (state_reg == IDLE && update) begin
                div_q_reg <= divisor;
            end
            if (state_reg == SETTLE) begin
                cnt_reg <= cnt_reg + CW'(1);
            end else begin
                cnt_reg <= '0;
            end
            if (state_reg == WR_HI) begin
                cur_divisor_reg <= div_q_reg;
            end
        end
    end

    always_comb begin
        wr_next      = 1'b0;
        ioaddr_next  = ioaddr_reg;
        databus_next = databus_reg;
        case (state_next)
            WR_LO: begin
                wr_next      = 1'b1;
                ioaddr_next  = ADDR_DBL;
                databus_next = div_q_reg[7:0];
            end
            WR_HI: begin
                wr_next      = 1'b1;
                ioaddr_next  = ADDR_DBH;
                databus_next = div_q_reg[15:8];
            end
            TX_WR: begin
                wr_next      = 1'b1;
                ioaddr_next  = ADDR_TX;
                databus_next = tx_data;
            end
            default: begin
                wr_next = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ak_reg       <= 1'b0;
            tx_grant_reg <= 1'b0;
            iocs_reg     <= 1'b0;
            iorw_reg     <= 1'b1;
            ioaddr_reg   <= 2'b00;
            databus_reg  <= 8'h00;
            cfg_busy_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            ak_reg       <= (state_next == ACK);
            tx_grant_reg <= (state_next == TX_WR);
            iocs_reg     <= wr_next;
            iorw_reg     <= ~wr_next;
            ioaddr_reg   <= ioaddr_next;
            databus_reg  <= databus_next;
            cfg_busy_reg <= (state_next != IDLE);
            cfg_err_reg  <= (state_reg == ACK) && (div_q_reg == 16'd0);
        end
    end

    assign AK          = ak_reg;
    assign tx_grant    = tx_grant_reg;
    assign iocs        = iocs_reg;
    assign iorw        = iorw_reg;
    assign ioaddr      = ioaddr_reg;
    assign databus_out = databus_reg;
    assign cur_divisor = cur_divisor_reg;
    assign cfg_busy    = cfg_busy_reg;
    assign cfg_err     = cfg_err_reg;

endmodule
